// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for the UART receive path: one mid-bit sample strobe and one
// end-of-bit shift strobe per bit, then a single-cycle packet_done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | counters held at 0; a high timer_enable latches the config and starts
// RUN   | cycle counter runs 1..P_l, bit counter advances on each bit end
// DONE  | last bit has ended; packet_done and final bit_count are issued
module uart_rx_bit_timer #(
    parameter int CNT_W = 14,
    parameter int BIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_enable,
    input  logic [CNT_W-1:0] clks_per_bit,
    input  logic [BIT_W-1:0] bits_per_packet,
    output logic             sample_strobe,
    output logic             shift_strobe,
    output logic             packet_done,
    output logic [BIT_W-1:0] bit_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nx;
    logic [CNT_W-1:0] per_l, per_l_nx;
    logic [CNT_W-1:0] half_l, half_l_nx;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [BIT_W-1:0] bits_l, bits_l_nx;

    logic             sample_nx;
    logic             shift_nx;
    logic             done_nx;
    logic             busy_nx;
    logic [BIT_W-1:0] bit_count_nx;

    logic [CNT_W-1:0] per_clamp;
    logic [BIT_W-1:0] bits_clamp;

    // A period below 2 would put the sample point on top of the shift point.
    assign per_clamp  = (clks_per_bit < CNT_W'(2)) ? CNT_W'(2) : clks_per_bit;
    assign bits_clamp = (bits_per_packet == '0) ? BIT_W'(1) : bits_per_packet;

    // Outputs are computed from the next-cycle view and registered below, so
    // every output flop updates on the same edge as the state transition.
    always_comb begin
        state_nx     = state;
        cyc_cnt_nx   = cyc_cnt;
        bit_cnt_nx   = bit_cnt;
        per_l_nx     = per_l;
        half_l_nx    = half_l;
        bits_l_nx    = bits_l;
        sample_nx    = 1'b0;
        shift_nx     = 1'b0;
        done_nx      = 1'b0;
        busy_nx      = 1'b0;
        bit_count_nx = '0;

        case (state)
            S_IDLE: begin
                cyc_cnt_nx = '0;
                bit_cnt_nx = '0;
                if (timer_enable) begin
                    state_nx   = S_RUN;
                    per_l_nx   = per_clamp;
                    half_l_nx  = per_clamp >> 1;
                    bits_l_nx  = bits_clamp;
                    cyc_cnt_nx = CNT_W'(1);
                    busy_nx    = 1'b1;
                end
            end

            S_RUN: begin
                if (!timer_enable) begin
                    state_nx   = S_IDLE;
                    cyc_cnt_nx = '0;
                    bit_cnt_nx = '0;
                end else begin
                    busy_nx      = 1'b1;
                    bit_count_nx = bit_cnt;
                    sample_nx    = (cyc_cnt == half_l);
                    if (cyc_cnt == per_l) begin
                        shift_nx   = 1'b1;
                        cyc_cnt_nx = CNT_W'(1);
                        bit_cnt_nx = bit_cnt + BIT_W'(1);
                        if (bit_cnt == bits_l - BIT_W'(1)) begin
                            state_nx   = S_DONE;
                            cyc_cnt_nx = '0;
                        end
                    end else begin
                        cyc_cnt_nx = cyc_cnt + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_nx     = S_IDLE;
                done_nx      = 1'b1;
                busy_nx      = 1'b1;
                bit_count_nx = bit_cnt;
                cyc_cnt_nx   = '0;
                bit_cnt_nx   = '0;
            end

            default: begin
                state_nx   = S_IDLE;
                cyc_cnt_nx = '0;
                bit_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            per_l         <= CNT_W'(2);
            half_l        <= CNT_W'(1);
            bits_l        <= BIT_W'(1);
            sample_strobe <= 1'b0;
            shift_strobe  <= 1'b0;
            packet_done   <= 1'b0;
            bit_count     <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            cyc_cnt       <= cyc_cnt_nx;
            bit_cnt       <= bit_cnt_nx;
            per_l         <= per_l_nx;
            half_l        <= half_l_nx;
            bits_l        <= bits_l_nx;
            sample_strobe <= sample_nx;
            shift_strobe  <= shift_nx;
            packet_done   <= done_nx;
            bit_count     <= bit_count_nx;
            busy          <= busy_nx;
        end
    end

endmodule
